// File: rtl/uart_host_pkg.sv
// Shared types and defaults for the host UART controller: TX state encoding,
// protocol bytes and header geometry.
package uart_host_pkg;

    localparam int HEADER_W         = 640;
    localparam int HEADER_BYTES_DEF = HEADER_W / 8;

    localparam logic [7:0] ACK_BYTE_DEF  = 8'hA5;
    localparam logic [7:0] NONCE_TAG_DEF = 8'h4E;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_LOAD,
        TX_WAIT_HI,
        TX_WAIT_LO
    } tx_state_e;

    // Byte idx of a nonce report: the tag first, then the nonce big-endian.
    function automatic logic [7:0] nonce_byte(input logic [31:0] nonce,
                                              input logic [2:0]  idx,
                                              input logic [7:0]  tag);
        logic [7:0] b;
        case (idx)
            3'd0:    b = tag;
            3'd1:    b = nonce[31:24];
            3'd2:    b = nonce[23:16];
            3'd3:    b = nonce[15:8];
            3'd4:    b = nonce[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/uart_tx_sched.sv
// Shares the single UART transmitter between the header acknowledge and the
// found-nonce report; a started sequence always runs to completion.
module uart_tx_sched
    import uart_host_pkg::*;
#(
    parameter logic [7:0] ACK_BYTE  = ACK_BYTE_DEF,
    parameter logic [7:0] NONCE_TAG = NONCE_TAG_DEF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ack_req_i,
    input  logic [31:0] nonce_i,
    input  logic        nonce_valid_i,
    output logic        nonce_ready_o,
    input  logic        tx_busy_i,
    output logic        tx_wr_en_o,
    output logic [7:0]  tx_din_o
);

    tx_state_e   state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [1:0]  guard_q, guard_d;
    logic        sel_nonce_q, sel_nonce_d;
    logic [7:0]  din_q, din_d;
    logic        ack_pend_q, nonce_pend_q;
    logic [31:0] nonce_q;
    logic        seq_done;
    logic        accept;

    assign nonce_ready_o = ~nonce_pend_q & ~reset;
    assign accept        = nonce_valid_i & nonce_ready_o;
    assign tx_din_o      = din_q;

    // tx_din is registered on entry to TX_LOAD so it is stable with wr_en.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        guard_d     = guard_q;
        sel_nonce_d = sel_nonce_q;
        din_d       = din_q;
        tx_wr_en_o  = 1'b0;
        seq_done    = 1'b0;
        case (state_q)
            TX_IDLE: begin
                if (nonce_pend_q) begin
                    sel_nonce_d = 1'b1;
                    idx_d       = 3'd0;
                    din_d       = NONCE_TAG;
                    state_d     = TX_LOAD;
                end else if (ack_pend_q) begin
                    sel_nonce_d = 1'b0;
                    idx_d       = 3'd0;
                    din_d       = ACK_BYTE;
                    state_d     = TX_LOAD;
                end
            end
            TX_LOAD: begin
                if (!tx_busy_i && !reset) begin
                    tx_wr_en_o = 1'b1;
                    guard_d    = 2'd0;
                    state_d    = TX_WAIT_HI;
                end
            end
            TX_WAIT_HI: begin
                if (tx_busy_i || guard_q == 2'd3) begin
                    state_d = TX_WAIT_LO;
                end else begin
                    guard_d = guard_q + 2'd1;
                end
            end
            TX_WAIT_LO: begin
                if (!tx_busy_i) begin
                    if (sel_nonce_q && idx_q != 3'd4) begin
                        idx_d   = idx_q + 3'd1;
                        din_d   = nonce_byte(nonce_q, idx_q + 3'd1, NONCE_TAG);
                        state_d = TX_LOAD;
                    end else begin
                        seq_done = 1'b1;
                        state_d  = TX_IDLE;
                    end
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= TX_IDLE;
            idx_q        <= 3'd0;
            guard_q      <= 2'd0;
            sel_nonce_q  <= 1'b0;
            din_q        <= 8'h00;
            ack_pend_q   <= 1'b0;
            nonce_pend_q <= 1'b0;
            nonce_q      <= 32'h0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            guard_q     <= guard_d;
            sel_nonce_q <= sel_nonce_d;
            din_q       <= din_d;
            if (accept) begin
                nonce_q      <= nonce_i;
                nonce_pend_q <= 1'b1;
            end else if (seq_done && sel_nonce_q) begin
                nonce_pend_q <= 1'b0;
            end
            // A new header completion wins over clearing, so acks coalesce.
            if (ack_req_i) begin
                ack_pend_q <= 1'b1;
            end else if (seq_done && !sel_nonce_q) begin
                ack_pend_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/uart_host_ctrl.sv
// Host-side UART sequencer: assembles received bytes into the block header for
// the hasher and feeds acknowledges and nonce reports to the transmitter.
module uart_host_ctrl
    import uart_host_pkg::*;
#(
    parameter int         HEADER_BYTES = HEADER_BYTES_DEF,
    parameter int         RX_TIMEOUT   = 1000000,
    parameter logic [7:0] ACK_BYTE     = ACK_BYTE_DEF,
    parameter logic [7:0] NONCE_TAG    = NONCE_TAG_DEF
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      rx_rdy,
    input  logic [7:0]                rx_data,
    output logic                      rx_rdy_clr,
    input  logic                      tx_busy,
    output logic                      tx_wr_en,
    output logic [7:0]                tx_din,
    output logic [8*HEADER_BYTES-1:0] header_data,
    output logic                      header_valid,
    input  logic [31:0]               nonce_in,
    input  logic                      nonce_valid,
    output logic                      nonce_ready,
    output logic [15:0]               rx_err_count
);

    localparam int HW = 8 * HEADER_BYTES;
    localparam int CW = $clog2(HEADER_BYTES);
    localparam logic [CW-1:0] LAST_IDX = CW'(HEADER_BYTES - 1);

    logic [CW-1:0] cnt_q;
    logic [31:0]   idle_q;
    logic [HW-1:0] shadow_q, shadow_d;
    logic [HW-1:0] header_q;
    logic          clr_q;
    logic          valid_q;
    logic [15:0]   err_q;
    logic          capture;

    assign capture  = rx_rdy & ~clr_q;
    assign shadow_d = {shadow_q[HW-9:0], rx_data};

    assign rx_rdy_clr   = clr_q;
    assign header_data  = header_q;
    assign header_valid = valid_q;
    assign rx_err_count = err_q;

    // The completing byte is folded in directly so the header loads in one shot.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q    <= '0;
            idle_q   <= 32'd0;
            shadow_q <= '0;
            header_q <= '0;
            clr_q    <= 1'b0;
            valid_q  <= 1'b0;
            err_q    <= 16'h0000;
        end else begin
            clr_q   <= capture;
            valid_q <= 1'b0;
            if (capture) begin
                shadow_q <= shadow_d;
                idle_q   <= 32'd0;
                if (cnt_q == LAST_IDX) begin
                    cnt_q    <= '0;
                    header_q <= shadow_d;
                    valid_q  <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end else if (cnt_q != '0) begin
                if (idle_q >= 32'(RX_TIMEOUT)) begin
                    cnt_q  <= '0;
                    idle_q <= 32'd0;
                    if (err_q != 16'hFFFF) begin
                        err_q <= err_q + 16'd1;
                    end
                end else begin
                    idle_q <= idle_q + 32'd1;
                end
            end else begin
                idle_q <= 32'd0;
            end
        end
    end

    uart_tx_sched #(
        .ACK_BYTE  (ACK_BYTE),
        .NONCE_TAG (NONCE_TAG)
    ) u_tx_sched (
        .clock         (clock),
        .reset         (reset),
        .ack_req_i     (valid_q),
        .nonce_i       (nonce_in),
        .nonce_valid_i (nonce_valid),
        .nonce_ready_o (nonce_ready),
        .tx_busy_i     (tx_busy),
        .tx_wr_en_o    (tx_wr_en),
        .tx_din_o      (tx_din)
    );

endmodule
